serial_subtractor_ctrl: RTL and testbench

//  Bit-serial multi-bit subtractor: sequences one full_subtractor cell over WIDTH cycles to form

---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/full_subtractor.sv | 16 +
 rtl/serial_subtractor_ctrl.sv | 105 ++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: controller state enum and
// its encoding constants.
package serial_sub_pkg;

  localparam logic [1:0] IDLE_ENC  = 2'd0;
  localparam logic [1:0] SHIFT_ENC = 2'd1;
  localparam logic [1:0] DONE_ENC  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = IDLE_ENC,
    SHIFT = SHIFT_ENC,
    DONE  = DONE_ENC
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: diff = a - b - bin, borrow out of the bit.
module full_subtractor (
  output logic diff,
  output logic borrow,
  input  logic a,
  input  logic b,
  input  logic bin
);

  // Pure combinational difference and borrow for one bit position
  always_comb begin
    diff   = a ^ b ^ bin;
    borrow = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: one full_subtractor cell is reused over WIDTH
// cycles to form diff = a - b - bin, LSB first, with a start/done handshake.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow
// output ovf (borrow into MSB XOR borrow out of MSB).
module serial_subtractor_ctrl
  import serial_sub_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   res_sr;
  logic               brw;
  logic [CNT_W-1:0]   count;
  logic               fs_d;
  logic               fs_bo;
  logic               last_bit;

  full_subtractor u_fs (fs_d, fs_bo, a_sr[0], b_sr[0], brw);

  assign last_bit = (count == CNT_W'(WIDTH - 1));
  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: start only matters in IDLE, DONE lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, serial shift/borrow chain, and result registers that
  // load only on the final step so partial results are never visible
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      brw    <= 1'b0;
      count  <= '0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            brw   <= bin;
            count <= '0;
          end
        end
        SHIFT: begin
          res_sr <= {fs_d, res_sr[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          brw    <= fs_bo;
          count  <= count + 1'b1;
          if (last_bit) begin
            diff <= {fs_d, res_sr[WIDTH-1:1]};
            bout <= fs_bo;
`ifdef SERIAL_SUB_OVF_EN
            // brw here is still the borrow into the MSB
            ovf  <= brw ^ fs_bo;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl (WIDTH=8): directed
// literal cases plus randomized traffic against a transaction-level model.
module tb_serial_subtractor_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int nvec = 0;
  int nerr = 0;

  serial_subtractor_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // A transaction occupies WIDTH cycles of busy, then one cycle of done.
  logic             m_busy = 1'b0;
  logic             m_done = 1'b0;
  logic [WIDTH-1:0] m_diff = '0;
  logic             m_bout = 1'b0;
  logic             m_ovf  = 1'b0;
  int               m_left = 0;
  int               m_a = 0, m_b = 0, m_bin = 0;
  int               sres;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_diff = '0; m_bout = 1'b0; m_ovf = 1'b0;
      m_left = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_diff = WIDTH'((m_a - m_b - m_bin) & ((1 << WIDTH) - 1));
        m_bout = (m_a < m_b + m_bin);
        sres   = ((m_a >= 128) ? m_a - 256 : m_a) - ((m_b >= 128) ? m_b - 256 : m_b) - m_bin;
        m_ovf  = (sres > 127) || (sres < -128);
      end
    end else if (start) begin
      m_a = int'(a); m_b = int'(b); m_bin = int'(bin);
      m_busy = 1'b1;
      m_left = WIDTH;
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("diff", 32'(diff), 32'(m_diff));
    chk("bout", 32'(bout), 32'(m_bout));
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
  end

  // Issue one operation and check the literal result and the latency
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                        input logic [7:0] ediff, input logic ebout, input logic eovf,
                        input string name);
    int lat;
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    a = ~ta; b = ~tb; bin = ~tbin;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 4 * WIDTH);
    chk({name, "_latency"}, 32'(lat), 32'(WIDTH + 1));
    chk({name, "_diff"}, 32'(diff), 32'(ediff));
    chk({name, "_bout"}, 32'(bout), 32'(ebout));
`ifdef SERIAL_SUB_OVF_EN
    chk({name, "_ovf"}, 32'(ovf), 32'(eovf));
`else
    if (eovf === 1'bx) $display("unexpected ovf literal");
`endif
    @(posedge clk); #2;
  endtask

  initial begin
    int ndone;
    logic [7:0] pick [4];
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    #1 rst = 1'b0;

    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "5m3");
    run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, "3m5");
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, "0m0b");
    run_op(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, "FFmFF");
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "80m01");
    run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "7FmFF");

    // Second start during SHIFT must be ignored: one done, first result
    a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    a = 8'hAA; b = 8'h11; bin = 1'b1; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    ndone = 0;
    repeat (2 * WIDTH + 4) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("ignore_diff", 32'(diff), 32'h0F);
      end
    end
    chk("ignore_ndone", 32'(ndone), 32'd1);
    @(posedge clk); #2;

    // Reset in the 4th SHIFT cycle aborts the operation
    a = 8'h40; b = 8'h22; bin = 1'b1; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_bout", 32'(bout), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    run_op(8'h40, 8'h22, 1'b1, 8'h1D, 1'b0, 1'b0, "after_rst");

    // Randomized traffic: start noise, boundary operands, rare resets
    pick[0] = 8'h00; pick[1] = 8'hFF; pick[2] = 8'h80; pick[3] = 8'h7F;
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 3) == 0);
      a     = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 8'($urandom);
      b     = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 8'($urandom);
      bin   = 1'($urandom);
      rst   = ($urandom_range(0, 299) == 0);
      @(posedge clk); #2;
      rst   = 1'b0;
    end
    start = 1'b0;
    repeat (WIDTH + 3) @(posedge clk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
